// File: rtl/spi_slave_port.sv
// SPI mode-0 responder. The pins are oversampled in the clk domain. A one-byte TX buffer and a
// one-byte RX holding register give the CPU side a strobe/flag handshake.
module spi_slave_port #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ss_n,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_full,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_rd,
    output logic       overrun,
    output logic       selected
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sck_prev_q;
    logic [7:0]             tx_buf_q, tx_sh_q, rx_sh_q, rx_data_q;
    logic                   tx_full_q, rx_valid_q, overrun_q;
    logic [2:0]             bitcnt_q;
    logic                   miso_q, miso_oe_q;

    logic       sck_s, ss_s, mosi_s, sck_rise, sck_fall;
    logic [7:0] load_d;

    always_comb begin
        sck_s    = sck_sync_q[SYNC_STAGES-1];
        ss_s     = ss_sync_q[SYNC_STAGES-1];
        mosi_s   = mosi_sync_q[SYNC_STAGES-1];
        sck_rise = sck_s & ~sck_prev_q;
        sck_fall = ~sck_s & sck_prev_q;
        // An empty buffer sends all-ones so the host sees an idle-high line.
        load_d   = tx_full_q ? tx_buf_q : 8'hFF;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sck_sync_q  <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            tx_buf_q    <= 8'h00;
            tx_full_q   <= 1'b0;
            tx_sh_q     <= 8'hFF;
            rx_sh_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            bitcnt_q    <= 3'd0;
            miso_q      <= 1'b1;
            miso_oe_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sck_prev_q  <= sck_s;

            // A byte completing in this cycle sets the flags again below.
            if (rx_rd) begin
                rx_valid_q <= 1'b0;
                overrun_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!ss_s) begin
                        state_q   <= SHIFT;
                        tx_sh_q   <= load_d;
                        tx_full_q <= 1'b0;
                        bitcnt_q  <= 3'd0;
                        miso_q    <= load_d[7];
                        miso_oe_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (ss_s) begin
                        state_q   <= IDLE;
                        bitcnt_q  <= 3'd0;
                        miso_q    <= 1'b1;
                        miso_oe_q <= 1'b0;
                    end else if (sck_rise) begin
                        rx_sh_q  <= {rx_sh_q[6:0], mosi_s};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            rx_data_q  <= {rx_sh_q[6:0], mosi_s};
                            rx_valid_q <= 1'b1;
                            if (rx_valid_q && !rx_rd)
                                overrun_q <= 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (bitcnt_q == 3'd0) begin
                            tx_sh_q   <= load_d;
                            tx_full_q <= 1'b0;
                            miso_q    <= load_d[7];
                        end else begin
                            tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                            miso_q  <= tx_sh_q[6];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // The CPU write lands after any shifter load, so the shifter keeps the old byte.
            if (tx_wr) begin
                tx_buf_q  <= tx_data;
                tx_full_q <= 1'b1;
            end
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = miso_oe_q;
    assign tx_full  = tx_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign overrun  = overrun_q;
    assign selected = ~ss_s;

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port. A host model clocks bytes in and out. A reference model, written
// as plain per-byte transactions, predicts the TX bytes and the RX flags.
module tb_spi_slave_port;

    logic       clk = 1'b0;
    logic       reset_n, ss_n, sck, mosi, tx_wr, rx_rd;
    logic [7:0] tx_data;
    logic       miso, miso_oe, tx_full, rx_valid, overrun, selected;
    logic [7:0] rx_data;

    int errs = 0;
    int checks = 0;

    // Reference model state
    logic       m_full, m_rxv, m_ovr;
    logic [7:0] m_buf, m_rxd, m_exp;

    spi_slave_port #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .ss_n(ss_n), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_wr(tx_wr),
        .tx_full(tx_full), .rx_data(rx_data), .rx_valid(rx_valid), .rx_rd(rx_rd),
        .overrun(overrun), .selected(selected)
    );

    always #5 clk = ~clk;

    task automatic mdl_load();
        m_exp  = m_full ? m_buf : 8'hFF;
        m_full = 1'b0;
    endtask

    task automatic cpu_wr(input logic [7:0] v);
        tx_data = v; tx_wr = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
        m_buf = v; m_full = 1'b1;
    endtask

    task automatic cpu_rd();
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
        m_rxv = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic select();
        ss_n = 1'b0;
        repeat (4) @(negedge clk);
        mdl_load();
    endtask

    task automatic deselect();
        ss_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Host side: 4 clk per sck phase. Optional CPU strobes land on the cycle the slave acts on
    // the last rise (completion) or on the last fall (reload).
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit rd_last,
                            input bit wr_last, input logic [7:0] wv, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = mo[i];
            repeat (4) @(negedge clk);
            mi[i] = miso;
            sck = 1'b1;
            if (i == 0 && rd_last) begin
                repeat (2) @(negedge clk);
                rx_rd = 1'b1;
                @(negedge clk);
                rx_rd = 1'b0;
                @(negedge clk);
            end else repeat (4) @(negedge clk);
            sck = 1'b0;
            if (i == 0 && wr_last) begin
                repeat (2) @(negedge clk);
                tx_data = wv; tx_wr = 1'b1;
                @(negedge clk);
                tx_wr = 1'b0;
                @(negedge clk);
            end else repeat (4) @(negedge clk);
        end
    endtask

    task automatic byte_step(input logic [7:0] mo, input bit rd, input bit wr, input logic [7:0] wv,
                             output logic [7:0] exp_mi, output logic [7:0] mi);
        exp_mi = m_exp;
        spi_xfer(mo, 8, rd, wr, wv, mi);
        if (rd) m_ovr = 1'b0;
        else if (m_rxv) m_ovr = 1'b1;
        m_rxv = 1'b1;
        m_rxd = mo;
        mdl_load();
        if (wr) begin m_buf = wv; m_full = 1'b1; end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        tx_wr = 1'b0; rx_rd = 1'b0; tx_data = 8'h00;
        m_full = 0; m_rxv = 0; m_ovr = 0; m_buf = 0; m_rxd = 0; m_exp = 8'hFF;
        repeat (3) @(negedge clk);
        checks++; if (miso !== 1'b1) begin errs++; $display("FAIL reset_miso: got %b exp 1", miso); end
        checks++; if (miso_oe !== 1'b0) begin errs++; $display("FAIL reset_oe: got %b exp 0", miso_oe); end
        checks++; if ({rx_valid, overrun, tx_full, selected} !== 4'b0) begin errs++;
            $display("FAIL reset_flags: got %b exp 0000", {rx_valid, overrun, tx_full, selected}); end
        checks++; if (rx_data !== 8'h00) begin errs++; $display("FAIL reset_rxdata: got %h exp 00", rx_data); end
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            mosi = 1'($urandom);
            repeat (4) @(negedge clk);
            sck = ~sck;
        end
        sck = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if ({miso, miso_oe, rx_valid, overrun, selected} !== 5'b10000) begin errs++;
            $display("FAIL idle_sck: got %b exp 10000", {miso, miso_oe, rx_valid, overrun, selected}); end
    endtask

    task automatic test_single_byte();
        logic [7:0] e, mi;
        cpu_wr(8'hA5);
        select();
        checks++; if ({miso_oe, miso, selected} !== 3'b111) begin errs++;
            $display("FAIL sel_oe: got %b exp 111", {miso_oe, miso, selected}); end
        byte_step(8'h3C, 0, 0, 8'h00, e, mi);
        checks++; if (mi !== 8'hA5 || e !== 8'hA5) begin errs++; $display("FAIL single_miso: got %h exp a5", mi); end
        checks++; if (rx_data !== 8'h3C || rx_valid !== 1'b1) begin errs++;
            $display("FAIL single_rx: got %h/%b exp 3c/1", rx_data, rx_valid); end
        checks++; if (tx_full !== 1'b0) begin errs++; $display("FAIL single_txfull: got %b exp 0", tx_full); end
        deselect();
        checks++; if ({miso_oe, miso, selected} !== 3'b010) begin errs++;
            $display("FAIL desel: got %b exp 010", {miso_oe, miso, selected}); end
        cpu_rd();
    endtask

    task automatic test_overrun();
        logic [7:0] e, m1, m2;
        select();
        byte_step(8'h11, 0, 0, 8'h00, e, m1);
        byte_step(8'h22, 0, 0, 8'h00, e, m2);
        checks++; if (m1 !== 8'hFF || m2 !== 8'hFF) begin errs++; $display("FAIL empty_tx: got %h %h exp ff ff", m1, m2); end
        checks++; if (rx_data !== 8'h22 || overrun !== 1'b1 || rx_valid !== 1'b1) begin errs++;
            $display("FAIL overrun_set: got %h/%b/%b exp 22/1/1", rx_data, overrun, rx_valid); end
        deselect();
        cpu_rd();
        checks++; if (rx_valid !== 1'b0 || overrun !== 1'b0) begin errs++;
            $display("FAIL overrun_clr: got %b/%b exp 0/0", rx_valid, overrun); end
    endtask

    task automatic test_simul_read();
        logic [7:0] e, mi;
        select();
        byte_step(8'h33, 0, 0, 8'h00, e, mi);
        byte_step(8'h44, 1, 0, 8'h00, e, mi);
        checks++; if (rx_valid !== 1'b1 || overrun !== 1'b0 || rx_data !== 8'h44) begin errs++;
            $display("FAIL simul_rd: got %b/%b/%h exp 1/0/44", rx_valid, overrun, rx_data); end
        deselect();
        cpu_rd();
    endtask

    task automatic test_abort();
        logic [7:0] e, mi;
        select();
        spi_xfer(8'hF0, 4, 0, 0, 8'h00, mi);
        ss_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (miso_oe !== 1'b0 || miso !== 1'b1) begin errs++;
            $display("FAIL abort_oe: got oe=%b miso=%b exp 0/1", miso_oe, miso); end
        checks++; if (rx_valid !== 1'b0 || rx_data !== m_rxd) begin errs++;
            $display("FAIL abort_rx: got %b/%h exp 0/%h", rx_valid, rx_data, m_rxd); end
        repeat (3) @(negedge clk);
        select();
        byte_step(8'h0F, 0, 0, 8'h00, e, mi);
        checks++; if (rx_data !== 8'h0F || rx_valid !== 1'b1 || overrun !== 1'b0) begin errs++;
            $display("FAIL abort_next: got %h/%b/%b exp 0f/1/0", rx_data, rx_valid, overrun); end
        deselect();
        cpu_rd();
    endtask

    task automatic test_load_boundary();
        logic [7:0] e, m1, m2, m3;
        cpu_wr(8'hAA);
        select();
        cpu_wr(8'h55);
        byte_step(8'h01, 0, 1, 8'h77, e, m1);
        checks++; if (tx_full !== 1'b1) begin errs++; $display("FAIL boundary_full: got %b exp 1", tx_full); end
        byte_step(8'h02, 0, 0, 8'h00, e, m2);
        byte_step(8'h03, 0, 0, 8'h00, e, m3);
        checks++; if ({m1, m2, m3} !== {8'hAA, 8'h55, 8'h77}) begin errs++;
            $display("FAIL boundary_bytes: got %h %h %h exp aa 55 77", m1, m2, m3); end
        deselect();
        cpu_rd();
    endtask

    task automatic test_random();
        logic [7:0] e, mi, wv;
        bit rd, wr;
        int nb;
        for (int f = 0; f < 16; f++) begin
            if ($urandom_range(1, 0) == 1) cpu_wr(8'($urandom));
            select();
            nb = $urandom_range(3, 1);
            for (int b = 0; b < nb; b++) begin
                rd = 1'($urandom); wr = 1'($urandom); wv = 8'($urandom);
                byte_step(8'($urandom), rd, wr, wv, e, mi);
                checks++; if (mi !== e) begin errs++; $display("FAIL rnd_miso f%0d b%0d: got %h exp %h", f, b, mi, e); end
                checks++; if ({rx_data, rx_valid, overrun, tx_full} !== {m_rxd, m_rxv, m_ovr, m_full}) begin errs++;
                    $display("FAIL rnd_state f%0d b%0d: got %h/%b/%b/%b exp %h/%b/%b/%b", f, b,
                             rx_data, rx_valid, overrun, tx_full, m_rxd, m_rxv, m_ovr, m_full); end
                if ($urandom_range(3, 0) == 0) cpu_rd();
                if ($urandom_range(3, 0) == 0) cpu_wr(8'($urandom));
            end
            deselect();
            checks++; if ({miso_oe, miso, selected, tx_full} !== {3'b010, m_full}) begin errs++;
                $display("FAIL rnd_idle f%0d: got %b exp %b", f, {miso_oe, miso, selected, tx_full}, {3'b010, m_full}); end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_overrun();
        test_simul_read();
        test_abort();
        test_load_boundary();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_port.md
# spi_slave_port

SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) that lets the system act as the far end of an SPI link driven by an external or on-chip SPI host. External `sck`/`mosi`/`ss_n` are oversampled in the `clk` domain, so no second clock domain is introduced. A one-byte receive holding register and a one-byte transmit buffer give the CPU side a simple strobe/flag handshake. The block sits between the SPI pins and the CPU I/O register decoder.

## Interface
- `SYNC_STAGES`, 2, synchronizer depth applied to `sck`, `mosi` and `ss_n` (minimum 2).
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset. Clock is `clk`.
- `ss_n` in 1: slave select, active low, asynchronous to `clk`.
- `sck` in 1: SPI clock, asynchronous to `clk`, idle low.
- `mosi` in 1: host-to-slave data.
- `miso` out 1: slave-to-host data. Driven 1 when not selected.
- `miso_oe` out 1: output enable for an external tristate; 1 only while selected.
- `tx_data` in 8: next byte to send.
- `tx_wr` in 1: single-cycle strobe; writes `tx_data` into the TX buffer.
- `tx_full` out 1: TX buffer holds a byte not yet consumed by the shifter.
- `rx_data` out 8: last complete received byte.
- `rx_valid` out 1: `rx_data` unread.
- `rx_rd` in 1: single-cycle strobe; acknowledges `rx_data`.
- `overrun` out 1: a byte completed while `rx_valid` was already 1. Sticky.
- `selected` out 1: synchronized, inverted `ss_n`.

## Operation
- **Synchronization:** each of `sck`, `mosi` and `ss_n` passes through `SYNC_STAGES` flops. Edges are detected on the synchronized `sck` by comparing it with a one-cycle-delayed copy, giving `sck_rise` and `sck_fall`.
- **State machine:** two states, IDLE and SHIFT.
  - **IDLE → SHIFT** on synchronized `ss_n`=0. On the same cycle:
    - `tx_sh` ← (`tx_full` ? `tx_buf` : 8'hFF);
    - `tx_full` ← 0;
    - `bitcnt` ← 0;
    - `miso` ← bit 7 of the loaded value;
    - `miso_oe` ← 1.
  - **SHIFT, `sck_rise`:**
    - `rx_sh` ← {`rx_sh[6:0]`, `mosi_s`};
    - `bitcnt` ← `bitcnt`+1 (3-bit, wraps at 8).
    - If `bitcnt`==7, the byte is complete:
      - `rx_data` ← {`rx_sh[6:0]`, `mosi_s`};
      - `rx_valid` ← 1;
      - `overrun` ← 1 if `rx_valid` was 1 and `rx_rd` is not asserted this cycle.
  - **SHIFT, `sck_fall`:**
    - If `bitcnt`==0 (byte boundary): reload `tx_sh` exactly as on entry, clear `tx_full`, and drive `miso` from the new bit 7.
    - Otherwise: `tx_sh` ← `tx_sh`<<1 and `miso` ← `tx_sh[6]`.
  - **SHIFT → IDLE** on synchronized `ss_n`=1, any bit position. A partial byte is discarded and `rx_valid`/`rx_data` are unchanged. `bitcnt` ← 0, `miso` ← 1, `miso_oe` ← 0.
- **TX buffer:**
  - `tx_wr` sets `tx_full` and overwrites `tx_buf` even when `tx_full` is already 1; the last write wins.
  - `tx_wr` on the same cycle as a shifter load: the shifter takes the old buffer contents (or FF if the buffer was empty), then `tx_buf` ← `tx_data` and `tx_full` stays 1.
- **RX handshake:**
  - `rx_rd` clears `rx_valid` and `overrun`.
  - `rx_rd` on the same cycle as byte completion: `rx_valid` stays 1, `overrun` is not set, and `rx_data` takes the new byte.
- **Reset values:**
  - `miso`=1, `miso_oe`=0, `rx_data`=0, `rx_valid`=0, `overrun`=0, `tx_full`=0, `selected`=0;
  - internal `tx_buf`=0, `tx_sh`=FF, `bitcnt`=0, state IDLE;
  - synchronizers reset to `sck`=0, `ss_n`=1, `mosi`=0.

## Timing
- **Clock ratio:** `sck` high and low phases must each be ≥ `SYNC_STAGES`+1 `clk` periods; faster `sck` is unsupported.
- **Host timing:** the host must not drive the first `sck` rise until ≥ `SYNC_STAGES`+2 `clk` cycles after `ss_n` falls.
- **Latencies (`SYNC_STAGES`=2):**
  - `ss_n` fall → `miso_oe`/`miso` valid: 3 `clk`.
  - `sck` fall → `miso` update: 3 `clk`.
  - 8th `sck` rise → `rx_valid`=1 (with `rx_data` updated in the same cycle): 3 `clk`.
- **CPU-side strobes:** `tx_wr` and `rx_rd` take effect on the next `clk` edge and are level-sampled every cycle.
- **Bit timing:** `mosi` is sampled at the synchronized rising edge and must be stable ≥ `SYNC_STAGES`+1 `clk` around the `sck` rise.

## Test plan
- **Idle reset:** reset, hold `ss_n`=1 → `miso`=1, `miso_oe`=0, all flags 0. Toggling `sck` has no effect.
- **Single byte exchange:** `tx_wr` 8'hA5; select; host clocks out 8'h3C → host receives A5; `rx_data`=3C, `rx_valid`=1, `tx_full`=0.
- **Empty TX and overrun:** two back-to-back bytes 8'h11, 8'h22 with empty TX and no `rx_rd` → host receives FF, FF; `rx_data`=22, `overrun`=1. Then `rx_rd` → `rx_valid`=0, `overrun`=0.
- **Simultaneous read and completion:** assert `rx_rd` on the cycle the 2nd byte completes → `rx_valid`=1, `overrun`=0, `rx_data`=2nd byte.
- **Abort mid-byte:** deassert `ss_n` after 4 bits of 8'hF0, then reselect and send 8'h0F → only 0F is reported. `miso_oe` drops within 3 `clk` of the abort.
- **Write at load boundary:** `tx_wr` 8'h77 on the cycle of the byte-boundary reload, with 8'h55 already buffered → current byte is 55, next byte is 77.
